axis_s_capture: RTL and testbench
=================================

# axis_s_capture

AXI-Stream slave that receives packets beat by beat and packs them into an internal byte buffer. It reports each completed packet's length, beat count and final tkeep to the simulation bridge, then holds the packet until the bridge acknowledges it. It is the receive-side counterpart of the bridge's stream master: it sits downstream of the DUT's AXI-Stream output and feeds the host side of the NIC sim bridge.

## Interface
- DATAW, 64, stream data width in bits; multiple of 8
- KEEPW, DATAW/8, tkeep width; always derived from DATAW
- DTMP, 4096, buffer capacity in bytes; multiple of KEEPW
- S_AXI_ACLK  in  1  sole clock; all logic on rising edge
- S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low
- s_axis_tdata  in  DATAW  beat data; byte i at [i*8+:8]
- s_axis_tkeep  in  KEEPW  byte enables
- s_axis_tlast  in  1  last beat of packet
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  block accepts beat
- o_pkt_valid  out  1  complete packet held in buffer
- o_pkt_len  out  32  packet length in bytes
- o_pkt_beats  out  32  beats received, including dropped beats
- o_last_keep  out  KEEPW  tkeep of the tlast beat
- o_overflow  out  1  packet exceeded DTMP; excess bytes dropped
- o_keep_err  out  1  a non-last beat had tkeep != all-ones
- i_pkt_ack  in  1  bridge has consumed the packet
- i_rd_addr  in  32  byte address into the buffer
- o_rd_data  out  8  buffer byte, registered

## Operation
- States: RECV and HOLD. Reset enters RECV.
- RECV behaviour:
  - s_axis_tready=1.
  - A beat is accepted when tvalid&&tready.
  - Accepted beat n (0-based) writes byte j to buf[n*KEEPW+j] for all j, regardless of tkeep.
  - Beat counter increments by 1.
- Overflow: if n*KEEPW >= DTMP, the beat is still accepted but not written, and the overflow flag sets. Stream never stalls for overflow.
- Keep check: a non-last accepted beat with tkeep != {KEEPW{1}} sets the keep-error flag. Its data is stored anyway.
- On an accepted beat with tlast=1:
  - o_pkt_len = (beats-1)*KEEPW + popcount(tkeep), counting the last beat; saturates at DTMP when overflow is set.
  - o_last_keep = tkeep; o_pkt_beats = total beats.
  - Flags are latched to o_overflow and o_keep_err.
  - Go to HOLD.
- A tlast beat with tkeep=0 is legal. It contributes 0 bytes.
- HOLD behaviour:
  - s_axis_tready=0 and o_pkt_valid=1.
  - Outputs stay stable and the buffer is frozen.
  - On i_pkt_ack=1: return to RECV, clear counters and internal flags, drive o_pkt_valid=0. o_pkt_len, o_pkt_beats, o_last_keep, o_overflow and o_keep_err clear to 0.
- i_pkt_ack in RECV is ignored.
- Read port: o_rd_data = buf[i_rd_addr] one cycle after the address. Valid in any state; contents are defined only in HOLD. Out-of-range address (>= DTMP) returns 0.
- Reset mid-packet discards the partial packet, clears all counters and flags, and returns to RECV. Buffer contents need not be cleared.

## Timing
- Reset values: s_axis_tready=0, o_pkt_valid=0, o_pkt_len=0, o_pkt_beats=0, o_last_keep=0, o_overflow=0, o_keep_err=0, o_rd_data=0.
- s_axis_tready is registered.
  - First rising edge after reset deassertion: tready rises to 1.
  - Edge that accepts the tlast beat: tready falls to 0.
- o_pkt_valid and all packet outputs update on the same edge that accepts the tlast beat, so they are visible the cycle after the handshake.
- Ack latency:
  - i_pkt_ack sampled high in HOLD: o_pkt_valid=0 and tready=1 after that edge.
  - The next beat can be accepted in the following cycle.
  - Minimum gap between packets is therefore 1 cycle of tready=0 plus the ack cycle.
- Back-to-back beats are accepted at 1 beat per cycle with no bubbles in RECV.
- tvalid without tready: the beat is held by the upstream per AXI-Stream rules. The block samples only on handshake.
- Counters are 32-bit. Beat count wrap is outside scope; packets longer than 2^32 beats are not supported.

## Test plan
- 3 back-to-back beats, bytes 0x00..0x17, last tkeep=0x0F (DATAW=64) -> o_pkt_valid one cycle after tlast; o_pkt_len=20, o_pkt_beats=3, o_last_keep=0x0F; reads of addr 0..19 return 0x00..0x13 with 1-cycle latency.
- Single beat, tkeep=0xFF, tlast=1 -> len=8, beats=1, tready=0 until ack; ack -> tready=1 next cycle, all packet outputs 0.
- Second packet presented with tvalid=1 while in HOLD -> no beat accepted (tready=0) for 10 cycles; ack -> first beat accepted the cycle after ack, and the second packet captures correctly.
- DTMP=64, 10 full beats -> all beats accepted, o_overflow=1, o_pkt_len=64, o_pkt_beats=10; buffer holds beats 0..7 only.
- Beat 1 of 3 with tkeep=0x3F, last tkeep=0xFF -> o_keep_err=1, o_pkt_len=24.
- Reset asserted after 2 beats of a 4-beat packet -> all outputs at reset values immediately; a fresh 2-beat packet after release reports len=16, beats=2, no flags.

Source files
------------

// File: rtl/axis_s_capture.sv
// AXI-Stream slave that captures one packet into a byte-addressable buffer,
// reports its length/beats/last tkeep and holds it until the bridge acks.
module axis_s_capture #(
  parameter int DATAW = 64,
  parameter int KEEPW = DATAW / 8,
  parameter int DTMP  = 4096
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESETN,
  input  logic [DATAW-1:0]   s_axis_tdata,
  input  logic [KEEPW-1:0]   s_axis_tkeep,
  input  logic               s_axis_tlast,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic               o_pkt_valid,
  output logic [31:0]        o_pkt_len,
  output logic [31:0]        o_pkt_beats,
  output logic [KEEPW-1:0]   o_last_keep,
  output logic               o_overflow,
  output logic               o_keep_err,
  input  logic               i_pkt_ack,
  input  logic [31:0]        i_rd_addr,
  output logic [7:0]         o_rd_data
);

  localparam int WORDS = DTMP / KEEPW;
  localparam int WAW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int SW    = (KEEPW > 1) ? $clog2(KEEPW) : 1;

  typedef enum logic {RECV = 1'b0, HOLD = 1'b1} state_t;

  state_t             state_reg;
  logic               tready_reg;
  logic               pkt_valid_reg;
  logic [31:0]        beat_cnt_reg;
  logic [31:0]        pkt_len_reg;
  logic [31:0]        pkt_beats_reg;
  logic [KEEPW-1:0]   last_keep_reg;
  logic               ovf_acc_reg;
  logic               kerr_acc_reg;
  logic               overflow_reg;
  logic               keep_err_reg;

  // Buffer is stored one beat per word; byte reads select within the word.
  logic [DATAW-1:0]   mem [0:WORDS-1];
  logic [DATAW-1:0]   rd_word_reg;
  logic [SW-1:0]      rd_sel_reg;
  logic               rd_inrange_reg;
  logic [7:0]         rd_bytes [0:KEEPW-1];

  logic               accept;
  logic               ovf_now;
  logic               kerr_now;
  logic [31:0]        keep_cnt;
  logic [31:0]        len_raw;

  // tready is only ever high in RECV, so the handshake alone qualifies a beat.
  assign accept   = s_axis_tvalid & tready_reg;
  assign ovf_now  = (beat_cnt_reg >= 32'(WORDS));
  assign kerr_now = !s_axis_tlast && (s_axis_tkeep != {KEEPW{1'b1}});
  assign len_raw  = (beat_cnt_reg * 32'(KEEPW)) + keep_cnt;

  always_comb begin
    keep_cnt = 32'd0;
    for (int j = 0; j < KEEPW; j++) begin
      keep_cnt = keep_cnt + {31'd0, s_axis_tkeep[j]};
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_reg     <= RECV;
      tready_reg    <= 1'b0;
      pkt_valid_reg <= 1'b0;
      beat_cnt_reg  <= 32'd0;
      pkt_len_reg   <= 32'd0;
      pkt_beats_reg <= 32'd0;
      last_keep_reg <= '0;
      ovf_acc_reg   <= 1'b0;
      kerr_acc_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      keep_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RECV: begin
          tready_reg <= 1'b1;
          if (accept) begin
            beat_cnt_reg <= beat_cnt_reg + 32'd1;
            ovf_acc_reg  <= ovf_acc_reg | ovf_now;
            kerr_acc_reg <= kerr_acc_reg | kerr_now;
            if (s_axis_tlast) begin
              state_reg     <= HOLD;
              tready_reg    <= 1'b0;
              pkt_valid_reg <= 1'b1;
              pkt_len_reg   <= (ovf_acc_reg | ovf_now) ? 32'(DTMP) : len_raw;
              pkt_beats_reg <= beat_cnt_reg + 32'd1;
              last_keep_reg <= s_axis_tkeep;
              overflow_reg  <= ovf_acc_reg | ovf_now;
              keep_err_reg  <= kerr_acc_reg | kerr_now;
            end
          end
        end
        HOLD: begin
          if (i_pkt_ack) begin
            state_reg     <= RECV;
            tready_reg    <= 1'b1;
            pkt_valid_reg <= 1'b0;
            beat_cnt_reg  <= 32'd0;
            pkt_len_reg   <= 32'd0;
            pkt_beats_reg <= 32'd0;
            last_keep_reg <= '0;
            ovf_acc_reg   <= 1'b0;
            kerr_acc_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            keep_err_reg  <= 1'b0;
          end
        end
        default: state_reg <= RECV;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (accept && !ovf_now) begin
      mem[beat_cnt_reg[WAW-1:0]] <= s_axis_tdata;
    end
    rd_word_reg <= mem[WAW'(i_rd_addr / 32'(KEEPW))];
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_inrange_reg <= 1'b0;
      rd_sel_reg     <= '0;
    end else begin
      rd_inrange_reg <= (i_rd_addr < 32'(DTMP));
      rd_sel_reg     <= SW'(i_rd_addr % 32'(KEEPW));
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < KEEPW; gi++) begin : g_rd_bytes
      assign rd_bytes[gi] = rd_word_reg[gi*8 +: 8];
    end
  endgenerate

  assign o_rd_data     = rd_inrange_reg ? rd_bytes[rd_sel_reg] : 8'd0;
  assign s_axis_tready = tready_reg;
  assign o_pkt_valid   = pkt_valid_reg;
  assign o_pkt_len     = pkt_len_reg;
  assign o_pkt_beats   = pkt_beats_reg;
  assign o_last_keep   = last_keep_reg;
  assign o_overflow    = overflow_reg;
  assign o_keep_err    = keep_err_reg;

endmodule

// File: tb/tb_axis_s_capture.sv
// Directed bench for axis_s_capture (DATAW=64, DTMP=64) with a packet-level
// reference model checked every cycle plus hand-computed literal checks.
module tb_axis_s_capture;

  localparam int DATAW = 64;
  localparam int KEEPW = 8;
  localparam int DTMP  = 64;

  logic              clk;
  logic              rst_n;
  logic [DATAW-1:0]  s_axis_tdata;
  logic [KEEPW-1:0]  s_axis_tkeep;
  logic              s_axis_tlast;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              o_pkt_valid;
  logic [31:0]       o_pkt_len;
  logic [31:0]       o_pkt_beats;
  logic [KEEPW-1:0]  o_last_keep;
  logic              o_overflow;
  logic              o_keep_err;
  logic              i_pkt_ack;
  logic [31:0]       i_rd_addr;
  logic [7:0]        o_rd_data;

  axis_s_capture #(.DATAW(DATAW), .KEEPW(KEEPW), .DTMP(DTMP)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .o_pkt_valid   (o_pkt_valid),
    .o_pkt_len     (o_pkt_len),
    .o_pkt_beats   (o_pkt_beats),
    .o_last_keep   (o_last_keep),
    .o_overflow    (o_overflow),
    .o_keep_err    (o_keep_err),
    .i_pkt_ack     (i_pkt_ack),
    .i_rd_addr     (i_rd_addr),
    .o_rd_data     (o_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: packet-level view of what the slave must report.
  logic        m_tready = 1'b0;
  logic        m_hold   = 1'b0;
  logic        m_valid  = 1'b0;
  logic [31:0] m_len    = 32'd0;
  logic [31:0] m_beats  = 32'd0;
  logic [7:0]  m_keep   = 8'd0;
  logic        m_ovf    = 1'b0;
  logic        m_kerr   = 1'b0;
  logic        m_rd_ok  = 1'b0;
  logic [7:0]  m_rd     = 8'd0;
  int          m_cnt    = 0;
  logic        m_kacc   = 1'b0;
  logic [7:0]  mem_m [0:DTMP-1];

  task automatic model_clear();
    m_valid = 1'b0; m_len = 32'd0; m_beats = 32'd0; m_keep = 8'd0;
    m_ovf = 1'b0; m_kerr = 1'b0; m_cnt = 0; m_kacc = 1'b0;
  endtask

  initial begin
    int tot;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_clear();
        m_tready = 1'b0;
        m_hold   = 1'b0;
        m_rd_ok  = 1'b0;
      end else begin
        m_rd_ok = m_hold;
        m_rd    = (i_rd_addr < 32'(DTMP)) ? mem_m[i_rd_addr[5:0]] : 8'd0;
        if (m_hold) begin
          if (i_pkt_ack) begin
            model_clear();
            m_hold   = 1'b0;
            m_tready = 1'b1;
          end
        end else if (m_tready && s_axis_tvalid) begin
          for (int j = 0; j < KEEPW; j++) begin
            if (m_cnt * KEEPW + j < DTMP) mem_m[m_cnt * KEEPW + j] = s_axis_tdata[j*8 +: 8];
          end
          if (!s_axis_tlast && s_axis_tkeep != 8'hFF) m_kacc = 1'b1;
          m_cnt++;
          if (s_axis_tlast) begin
            tot      = (m_cnt - 1) * KEEPW + $countones(s_axis_tkeep);
            m_len    = (tot > DTMP) ? 32'(DTMP) : 32'(tot);
            m_beats  = 32'(m_cnt);
            m_keep   = s_axis_tkeep;
            m_ovf    = (m_cnt * KEEPW > DTMP);
            m_kerr   = m_kacc;
            m_valid  = 1'b1;
            m_hold   = 1'b1;
            m_tready = 1'b0;
          end
        end else begin
          m_tready = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("tready",    {31'd0, s_axis_tready}, {31'd0, m_tready});
      chk("pkt_valid", {31'd0, o_pkt_valid},   {31'd0, m_valid});
      chk("pkt_len",   o_pkt_len,              m_len);
      chk("pkt_beats", o_pkt_beats,            m_beats);
      chk("last_keep", {24'd0, o_last_keep},   {24'd0, m_keep});
      chk("overflow",  {31'd0, o_overflow},    {31'd0, m_ovf});
      chk("keep_err",  {31'd0, o_keep_err},    {31'd0, m_kerr});
      if (!rst_n) chk("rd_data_rst", {24'd0, o_rd_data}, 32'd0);
      else if (m_rd_ok) chk("rd_data", {24'd0, o_rd_data}, {24'd0, m_rd});
    end
  end

  time last_acc_t;
  time first_acc_t;
  time ack_t;

  function automatic logic [63:0] mk(input int base);
    logic [63:0] d;
    for (int j = 0; j < 8; j++) d[j*8 +: 8] = 8'(base + j);
    return d;
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int   waited;
    logic hs;
    @(negedge clk);
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    waited = 0;
    forever begin
      hs = s_axis_tready;
      @(posedge clk);
      if (hs) begin
        last_acc_t = $time;
        $display("beat data=%016h keep=%02h last=%0b accepted at %0t", d, k, l, $time);
        break;
      end
      waited++;
      if (waited > 40) begin
        n_cmp++; n_bad++;
        $display("FAIL handshake_timeout: got no tready, expected acceptance at %0t", $time);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_pkt(input int nb, input int base, input logic [7:0] lkeep,
                          input int bad_idx, input logic [7:0] bad_keep);
    logic [7:0] k;
    for (int b = 0; b < nb; b++) begin
      k = (b == nb - 1) ? lkeep : ((b == bad_idx) ? bad_keep : 8'hFF);
      send_beat(mk(base + b * 8), k, (b == nb - 1));
      if (b == 0) first_acc_t = last_acc_t;
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic ack_pkt();
    @(negedge clk); i_pkt_ack = 1'b1;
    @(negedge clk); i_pkt_ack = 1'b0;
  endtask

  task automatic rd_chk(input int addr, input logic [7:0] exp);
    i_rd_addr = 32'(addr);
    @(negedge clk);
    chk("rd_lit", {24'd0, o_rd_data}, {24'd0, exp});
  endtask

  task automatic pkt_chk(input logic [31:0] len, input logic [31:0] beats, input logic [7:0] keep,
                         input logic ovf, input logic kerr);
    chk("lit_valid", {31'd0, o_pkt_valid}, 32'd1);
    chk("lit_len",   o_pkt_len, len);
    chk("lit_beats", o_pkt_beats, beats);
    chk("lit_keep",  {24'd0, o_last_keep}, {24'd0, keep});
    chk("lit_ovf",   {31'd0, o_overflow}, {31'd0, ovf});
    chk("lit_kerr",  {31'd0, o_keep_err}, {31'd0, kerr});
    chk("lit_tready_hold", {31'd0, s_axis_tready}, 32'd0);
    $display("packet len=%0d beats=%0d keep=%02h ovf=%0b kerr=%0b", o_pkt_len, o_pkt_beats,
             o_last_keep, o_overflow, o_keep_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; i_pkt_ack = 1'b0; i_rd_addr = 32'd0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("rst_len", o_pkt_len, 32'd0);
    chk("rst_rd", {24'd0, o_rd_data}, 32'd0);
    #2 rst_n = 1'b1;

    // 3 back-to-back beats, last tkeep 0x0F
    send_pkt(3, 8'h00, 8'h0F, -1, 8'hFF);
    pkt_chk(32'd20, 32'd3, 8'h0F, 1'b0, 1'b0);
    chk("b2b_timing", 32'(last_acc_t - first_acc_t), 32'd20);
    for (int i = 0; i < 20; i++) rd_chk(i, 8'(i));
    rd_chk(64, 8'h00);
    ack_pkt();
    chk("ack_tready", {31'd0, s_axis_tready}, 32'd1);
    chk("ack_valid", {31'd0, o_pkt_valid}, 32'd0);
    chk("ack_len", o_pkt_len, 32'd0);

    // single full beat, then hold with tready low until ack
    send_pkt(1, 8'h30, 8'hFF, -1, 8'hFF);
    pkt_chk(32'd8, 32'd1, 8'hFF, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_tready", {31'd0, s_axis_tready}, 32'd0);
    ack_pkt();
    chk("ack2_tready", {31'd0, s_axis_tready}, 32'd1);
    chk("ack2_beats", o_pkt_beats, 32'd0);
    chk("ack2_keep", {24'd0, o_last_keep}, 32'd0);

    // next packet presented while held; must wait for ack
    send_pkt(2, 8'h50, 8'hFF, -1, 8'hFF);
    fork
      send_pkt(2, 8'h70, 8'h03, -1, 8'hFF);
      begin
        repeat (10) @(negedge clk);
        i_pkt_ack = 1'b1;
        @(posedge clk);
        ack_t = $time;
        @(negedge clk);
        i_pkt_ack = 1'b0;
      end
    join
    chk("ack_to_accept", 32'(first_acc_t - ack_t), 32'd10);
    pkt_chk(32'd10, 32'd2, 8'h03, 1'b0, 1'b0);
    rd_chk(0, 8'h70);
    rd_chk(9, 8'h79);
    ack_pkt();

    // overflow: 10 full beats into a 64-byte buffer
    send_pkt(10, 8'h80, 8'hFF, -1, 8'hFF);
    pkt_chk(32'd64, 32'd10, 8'hFF, 1'b1, 1'b0);
    chk("ovf_timing", 32'(last_acc_t - first_acc_t), 32'd90);
    rd_chk(0, 8'h80);
    rd_chk(63, 8'hBF);
    rd_chk(56, 8'hB8);
    ack_pkt();

    // partial keep on a middle beat
    send_pkt(3, 8'h10, 8'hFF, 1, 8'h3F);
    pkt_chk(32'd24, 32'd3, 8'hFF, 1'b0, 1'b1);
    ack_pkt();

    // reset after 2 beats of a 4-beat packet
    send_beat(mk(8'h20), 8'hFF, 1'b0);
    send_beat(mk(8'h28), 8'hFF, 1'b0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("midrst_valid", {31'd0, o_pkt_valid}, 32'd0);
    chk("midrst_rd", {24'd0, o_rd_data}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    send_pkt(2, 8'h40, 8'hFF, -1, 8'hFF);
    pkt_chk(32'd16, 32'd2, 8'hFF, 1'b0, 1'b0);
    rd_chk(15, 8'h4F);
    ack_pkt();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
